uartrx: RTL and testbench

Serial receiver paired with the UART transmitter: it sits directly downstream of the tx line. It recovers 8N1 frames, LSB first, from an asynchronous input, and hands each byte to the host logic through a level-valid/ack interface. Overrun and framing errors are flagged. It accepts the transmitter's frames: idle-high, one start bit, 8 data bits, and one or more stop bits (extra stop bits are treated as idle).

---
 rtl/uartrx_sync2.sv | 25 ++
 rtl/uartrx.sv | 153 +++++++++++++++
 tb/tb_uartrx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uartrx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both stages reset high so an idle-high line shows no edge out of reset.
module sync2 (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uartrx.sv
// 8N1 UART receiver: synchronized line, edge-started frame timing,
// level-valid/ack byte handoff with sticky overrun and framing-error pulse.
module uartrx #(
    parameter int Baud      = 10_000_000,
    parameter int ClockRate = 50_000_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int Divider = ClockRate / Baud;
    localparam int H       = Divider / 2;
    localparam int TW      = $clog2(Divider + 1);

    localparam logic [TW-1:0] BitLoad  = TW'(Divider - 1);
    localparam logic [TW-1:0] HalfLoad = TW'(H - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    generate
        if (Divider < 4) begin : g_div_chk
            $error("uartrx: Divider must be >= 4");
        end
    endgenerate

    logic          rx_sync;
    logic          prev_q,    prev_d;
    state_e        state_q,   state_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic [2:0]    idx_q,     idx_d;
    logic [7:0]    shift_q,   shift_d;
    logic [7:0]    data_q,    data_d;
    logic          valid_q,   valid_d;
    logic          ovr_q,     ovr_d;
    logic          ferr_q,    ferr_d;
    logic          tick;

    sync2 u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (rx),
        .q    (rx_sync)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_q  <= 1'b1;
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign tick = (timer_q == '0);

    always_comb begin
        prev_d  = rx_sync;
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = 1'b0;

        if (rx_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_sync && prev_q) begin
                    state_d = START;
                    timer_d = HalfLoad;
                end
            end
            START: begin
                if (!tick) begin
                    timer_d = timer_q - TW'(1);
                end else if (rx_sync) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    timer_d = BitLoad;
                end
            end
            DATA: begin
                if (!tick) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    shift_d = {rx_sync, shift_q[7:1]};
                    timer_d = BitLoad;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    state_d = IDLE;
                    // a fresh byte beats a same-cycle ack
                    if (rx_sync) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ovr_d   = ovr_d | (valid_q & ~rx_ack);
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uartrx.sv
// Scoreboard bench for uartrx: directed frames at Divider 5, monitor
// pops expected bytes whenever a new byte appears on rx_data/rx_valid.
module tb_uartrx;

    localparam int D = 5;
    localparam int H = 2;

    typedef struct packed {
        logic [7:0] d;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       nrst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       rx_frame_err;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   fe_cnt = 0;
    exp_t exp_q[$];

    logic       mon_pv = 1'b0;
    logic [7:0] mon_pd = 8'h00;
    logic       mon_pf = 1'b0;

    uartrx dut (
        .clk          (clk),
        .nrst         (nrst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int x);
        int lim = 0;
        while (cyc < x && lim < 5000) begin
            tick1();
            lim++;
        end
        chk("wait_cycle", cyc, x);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (D) @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        tick1();
        rx_ack = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (nrst) begin
            if (rx_valid && (!mon_pv || rx_data != mon_pd)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'h0, rx_data}, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", {24'h0, rx_data}, {24'h0, e.d});
                    chk("sb_overrun", {31'h0, rx_overrun}, {31'h0, e.o});
                end
            end
            if (rx_frame_err) begin
                fe_cnt++;
                if (mon_pf) chk("ferr_width", 32'd2, 32'd1);
            end
        end
        mon_pv = rx_valid;
        mon_pd = rx_data;
        mon_pf = rx_frame_err;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        nrst   = 1'b0;
        rx     = 1'b1;
        rx_ack = 1'b0;
        #3;
        chk("rst_valid", {31'h0, rx_valid}, 32'h0);
        chk("rst_data", {24'h0, rx_data}, 32'h0);
        chk("rst_overrun", {31'h0, rx_overrun}, 32'h0);
        chk("rst_ferr", {31'h0, rx_frame_err}, 32'h0);
        repeat (3) tick1();
        nrst = 1'b1;
        repeat (5) tick1();

        // frame 0xA5, exact latency
        t0 = cyc + 1;
        exp_q.push_back('{d: 8'hA5, o: 1'b0});
        fork
            send(8'hA5, 1'b1);
            begin
                wait_until(t0 + 1 + H + 9 * D);
                chk("a5_valid_early", {31'h0, rx_valid}, 32'h0);
                wait_until(t0 + 2 + H + 9 * D);
                chk("a5_valid", {31'h0, rx_valid}, 32'h1);
                chk("a5_data", {24'h0, rx_data}, 32'hA5);
                chk("a5_ferr", {31'h0, rx_frame_err}, 32'h0);
                chk("a5_ovr", {31'h0, rx_overrun}, 32'h0);
            end
        join
        ack_pulse();
        chk("a5_acked", {31'h0, rx_valid}, 32'h0);
        repeat (4) tick1();

        // 2-cycle glitch: false start
        rx = 1'b0;
        repeat (2) tick1();
        rx = 1'b1;
        repeat (20) tick1();
        chk("glitch_valid", {31'h0, rx_valid}, 32'h0);
        chk("glitch_fe", fe_cnt, 0);

        // 0x3C with stop low, line then held low
        send(8'h3C, 1'b0);
        chk("fe_pulse", {31'h0, rx_frame_err}, 32'h1);
        tick1();
        chk("fe_end", {31'h0, rx_frame_err}, 32'h0);
        chk("fe_valid", {31'h0, rx_valid}, 32'h0);
        repeat (30) tick1();
        chk("fe_no_retrig", fe_cnt, 1);
        chk("fe_valid_hold", {31'h0, rx_valid}, 32'h0);
        rx = 1'b1;
        repeat (10) tick1();

        // back-to-back, no ack
        exp_q.push_back('{d: 8'h11, o: 1'b0});
        exp_q.push_back('{d: 8'h22, o: 1'b1});
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        chk("b2b_valid", {31'h0, rx_valid}, 32'h1);
        chk("b2b_data", {24'h0, rx_data}, 32'h22);
        chk("b2b_ovr", {31'h0, rx_overrun}, 32'h1);
        ack_pulse();
        chk("b2b_clr_valid", {31'h0, rx_valid}, 32'h0);
        chk("b2b_clr_ovr", {31'h0, rx_overrun}, 32'h0);
        repeat (4) tick1();

        // ack coincides with completing byte
        exp_q.push_back('{d: 8'h11, o: 1'b0});
        send(8'h11, 1'b1);
        exp_q.push_back('{d: 8'h55, o: 1'b0});
        t0 = cyc + 1;
        fork
            send(8'h55, 1'b1);
            begin
                wait_until(t0 + 1 + H + 9 * D);
                rx_ack = 1'b1;
                tick1();
                rx_ack = 1'b0;
            end
        join
        chk("ackc_valid", {31'h0, rx_valid}, 32'h1);
        chk("ackc_data", {24'h0, rx_data}, 32'h55);
        chk("ackc_ovr", {31'h0, rx_overrun}, 32'h0);
        repeat (4) tick1();

        // reset during data bit 4 of 0xFF
        t0 = cyc + 1;
        fork
            send(8'hFF, 1'b1);
            begin
                wait_until(t0 + 5 * D + 2);
                nrst = 1'b0;
                #1;
                chk("mrst_valid", {31'h0, rx_valid}, 32'h0);
                chk("mrst_data", {24'h0, rx_data}, 32'h0);
                chk("mrst_ovr", {31'h0, rx_overrun}, 32'h0);
                chk("mrst_ferr", {31'h0, rx_frame_err}, 32'h0);
                repeat (3) tick1();
                nrst = 1'b1;
            end
        join
        repeat (5) tick1();
        chk("post_rst_valid", {31'h0, rx_valid}, 32'h0);
        exp_q.push_back('{d: 8'h81, o: 1'b0});
        send(8'h81, 1'b1);
        chk("r81_valid", {31'h0, rx_valid}, 32'h1);
        chk("r81_data", {24'h0, rx_data}, 32'h81);
        chk("r81_ovr", {31'h0, rx_overrun}, 32'h0);
        repeat (5) tick1();

        chk("sb_drained", exp_q.size(), 0);
        chk("fe_total", fe_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
